// File: rtl/radix8_pp_reduce_pipe.sv
// radix8_pp_reduce_pipe
// Pipelined reducer for pre-aligned, sign-extended radix-8 partial products.
// NPP rows are reduced to a sum row and a carry row with 3:2 carry-save
// adders, then resolved by a ripple carry-propagate adder. All arithmetic
// is modulo 2^OUT_W.
//
// Pipeline: S0 (input regs) -> S1 (carry-save rows) -> S2 (CPA result).
// A single advance signal moves every stage at once. Bubbles are not squeezed,
// and a stalled output freezes the entire pipeline.
//
// Optional feature macro: RADIX8_PP_ACCUM_EN
//   When defined, S2 accumulates the beats of a run and emits one result
//   when the beat flagged with in_last reaches S2. When undefined, in_last is
//   ignored and every accepted beat produces one output.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   in_valid   in   pp_in beat valid
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   pp_in      in   NPP*OUT_W; partial product k is at [k*OUT_W +: OUT_W]
//   in_last    in   last beat of an accumulation run (accumulate build only)
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data
//   out_data   out  OUT_W reduced sum
module radix8_pp_reduce_pipe #(
    parameter int OUT_W = 16,
    parameter int NPP   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NPP*OUT_W-1:0] pp_in,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data
);

    if (NPP < 2 || NPP > 6) begin : g_bad_npp
        $error("radix8_pp_reduce_pipe: NPP must be in 2..6");
    end

    logic                 adv;

    logic                 v0_q, v0_d;
    logic [NPP*OUT_W-1:0] s0_pp_q, s0_pp_d;
    logic                 v1_q, v1_d;
    logic [OUT_W-1:0]     s1_sum_q, s1_sum_d;
    logic [OUT_W-1:0]     s1_carry_q, s1_carry_d;
    logic                 v2_q, v2_d;
    logic [OUT_W-1:0]     out_data_q, out_data_d;

    logic [OUT_W-1:0]     csa_sum, csa_carry, csa_sum_t, csa_pp;
    logic [OUT_W-1:0]     cpa_res;
    logic                 cpa_c;

`ifdef RADIX8_PP_ACCUM_EN
    logic                 s0_last_q, s0_last_d;
    logic                 s1_last_q, s1_last_d;
    logic [OUT_W-1:0]     acc_q, acc_d;
    logic                 first_q, first_d;
    logic [OUT_W-1:0]     total;
`else
    logic                 unused_in_last;
    assign unused_in_last = in_last;
`endif

    // Carry-save reduction: each added row folds into (sum, carry) with a 3:2
    // compressor; the carry row is shifted left with a zero LSB.
    always_comb begin
        csa_sum   = s0_pp_q[0 +: OUT_W];
        csa_carry = s0_pp_q[OUT_W +: OUT_W];
        csa_sum_t = '0;
        csa_pp    = '0;
        for (int k = 2; k < NPP; k++) begin
            csa_pp    = s0_pp_q[k*OUT_W +: OUT_W];
            csa_sum_t = csa_sum ^ csa_carry ^ csa_pp;
            csa_carry = ((csa_sum & csa_carry) | (csa_sum & csa_pp) |
                         (csa_carry & csa_pp)) << 1;
            csa_sum   = csa_sum_t;
        end
    end

    // Ripple carry-propagate adder; carry-out is dropped (modulo 2^OUT_W).
    always_comb begin
        cpa_res = '0;
        cpa_c   = 1'b0;
        for (int i = 0; i < OUT_W; i++) begin
            cpa_res[i] = s1_sum_q[i] ^ s1_carry_q[i] ^ cpa_c;
            cpa_c      = (s1_sum_q[i] & s1_carry_q[i]) |
                         (cpa_c & (s1_sum_q[i] ^ s1_carry_q[i]));
        end
    end

    assign adv = !v2_q | out_ready;

    always_comb begin
        v0_d       = v0_q;
        s0_pp_d    = s0_pp_q;
        v1_d       = v1_q;
        s1_sum_d   = s1_sum_q;
        s1_carry_d = s1_carry_q;
        v2_d       = v2_q;
        out_data_d = out_data_q;
`ifdef RADIX8_PP_ACCUM_EN
        s0_last_d  = s0_last_q;
        s1_last_d  = s1_last_q;
        acc_d      = acc_q;
        first_d    = first_q;
        total      = '0;
`endif
        if (adv) begin
            v0_d       = in_valid;
            s0_pp_d    = pp_in;
            v1_d       = v0_q;
            s1_sum_d   = csa_sum;
            s1_carry_d = csa_carry;
`ifdef RADIX8_PP_ACCUM_EN
            s0_last_d  = in_last;
            s1_last_d  = s0_last_q;
            v2_d       = 1'b0;
            if (v1_q) begin
                total = (first_q ? '0 : acc_q) + cpa_res;
                if (s1_last_q) begin
                    out_data_d = total;
                    v2_d       = 1'b1;
                    acc_d      = '0;
                    first_d    = 1'b1;
                end else begin
                    acc_d      = total;
                    first_d    = 1'b0;
                end
            end
`else
            v2_d       = v1_q;
            out_data_d = cpa_res;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_q       <= 1'b0;
            s0_pp_q    <= '0;
            v1_q       <= 1'b0;
            s1_sum_q   <= '0;
            s1_carry_q <= '0;
            v2_q       <= 1'b0;
            out_data_q <= '0;
`ifdef RADIX8_PP_ACCUM_EN
            s0_last_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            acc_q      <= '0;
            first_q    <= 1'b1;
`endif
        end else begin
            v0_q       <= v0_d;
            s0_pp_q    <= s0_pp_d;
            v1_q       <= v1_d;
            s1_sum_q   <= s1_sum_d;
            s1_carry_q <= s1_carry_d;
            v2_q       <= v2_d;
            out_data_q <= out_data_d;
`ifdef RADIX8_PP_ACCUM_EN
            s0_last_q  <= s0_last_d;
            s1_last_q  <= s1_last_d;
            acc_q      <= acc_d;
            first_q    <= first_d;
`endif
        end
    end

    assign in_ready  = adv;
    assign out_valid = v2_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_radix8_pp_reduce_pipe.sv
// Directed bench for radix8_pp_reduce_pipe (OUT_W=16, NPP=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_radix8_pp_reduce_pipe;

    localparam int OUT_W = 16;
    localparam int NPP   = 3;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [NPP*OUT_W-1:0] pp_in;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;

    int checks = 0;
    int errors = 0;

    radix8_pp_reduce_pipe #(.OUT_W(OUT_W), .NPP(NPP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp_in     (pp_in),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        pp_in = {c, b, a};
    endtask

    // One beat, then verify out_valid rises exactly on the third edge.
    task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] exp);
        set_pp(a, b, c);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_v1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_v2"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_v3"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp));
        tick();
        chk({tag, "_v4"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] stall_exp [0:2];

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b1;
        out_ready = 1'b1;
        pp_in     = '0;

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic sum and latency.
        send_one("basic", 16'h0011, 16'h0088, 16'h0400, 16'h0499);

        // Two's-complement wrap.
        send_one("wrap_a", 16'hFFF8, 16'h0018, 16'h0000, 16'h0010);
        send_one("wrap_b", 16'hFFFF, 16'h0001, 16'h0000, 16'h0000);

        // Back-to-back: beat c presented before edge c appears after edge c+2.
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) begin
                set_pp(16'(c), 16'hFFFF, 16'h0001);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 3 && c <= 6) begin
                chk($sformatf("b2b_v%0d", c), 32'(out_valid), 32'd1);
                chk($sformatf("b2b_d%0d", c), 32'(out_data), 32'(c - 2));
            end else begin
                chk($sformatf("b2b_v%0d", c), 32'(out_valid), 32'd0);
            end
        end
        tick();

        // Stall: fill with 0x0A, 0x0B, 0x0C while out_ready=0, then hold 0x0D.
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            set_pp(16'h1000, 16'(16'h000A + b), 16'hF000);
            in_valid = 1'b1;
            tick();
        end
        set_pp(16'h1000, 16'h000D, 16'hF000);
        chk("stall_full_rdy", 32'(in_ready), 32'd0);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("stall_rdy%0d", s), 32'(in_ready), 32'd0);
            chk($sformatf("stall_v%0d", s), 32'(out_valid), 32'd1);
            chk($sformatf("stall_d%0d", s), 32'(out_data), 32'h000A);
        end
        out_ready = 1'b1;
        #1;
        chk("stall_rel_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        stall_exp[0] = 16'h000B;
        stall_exp[1] = 16'h000C;
        stall_exp[2] = 16'h000D;
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("rel_v%0d", r), 32'(out_valid), 32'd1);
            chk($sformatf("rel_d%0d", r), 32'(out_data), 32'(stall_exp[r]));
            tick();
        end
        chk("rel_drain", 32'(out_valid), 32'd0);
        tick();

        // Reset with two beats in flight (0x55 at S2, 0x66 at S1).
        set_pp(16'h0050, 16'h0005, 16'h0000);
        in_valid = 1'b1;
        tick();
        set_pp(16'h0060, 16'h0006, 16'h0000);
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_v", 32'(out_valid), 32'd1);
        chk("pre_rst_d", 32'(out_data), 32'h0055);
        rst = 1'b0;
        #1;
        chk("mid_rst_v",   32'(out_valid), 32'd0);
        chk("mid_rst_d",   32'(out_data),  32'd0);
        chk("mid_rst_rdy", 32'(in_ready),  32'd1);
        tick();
        rst = 1'b1;
        send_one("post_rst", 16'h0100, 16'h0020, 16'h0007, 16'h0127);

`ifdef RADIX8_PP_ACCUM_EN
        // Three-beat run then a one-beat run.
        for (int c = 1; c <= 8; c++) begin
            in_valid = (c <= 4);
            in_last  = (c == 3 || c == 4);
            case (c)
                1:       set_pp(16'h0100, 16'h0000, 16'h0000);
                2:       set_pp(16'h0010, 16'h0010, 16'h0000);
                3:       set_pp(16'h0001, 16'h0001, 16'h0001);
                4:       set_pp(16'h0002, 16'h0003, 16'h0000);
                default: set_pp(16'h0000, 16'h0000, 16'h0000);
            endcase
            tick();
            if (c == 5) begin
                chk("acc_run3_v", 32'(out_valid), 32'd1);
                chk("acc_run3_d", 32'(out_data), 32'h0123);
            end else if (c == 6) begin
                chk("acc_run1_v", 32'(out_valid), 32'd1);
                chk("acc_run1_d", 32'(out_data), 32'h0005);
            end else begin
                chk($sformatf("acc_idle%0d", c), 32'(out_valid), 32'd0);
            end
        end
        in_last = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
